// File: rtl/mem_bank_scanner_pkg.sv
// Shared scan-sequencer types; other pipeline stages decode scan status from them.
package mem_bank_scanner_pkg;

  // Scan sequencer state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/mem_bank_scanner_pipeline_sr.sv
// Free-running shift register: q is d delayed by ENDING_CYCLE clocks.
// Ports: clk, reset (sync, active-high, clears every stage), d (input word),
//        q (word from ENDING_CYCLE cycles ago). ENDING_CYCLE must be >= 1.
module mem_bank_scanner_pipeline_sr #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned ENDING_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [ENDING_CYCLE-1:0][WIDTH-1:0] stage_q;
  logic [ENDING_CYCLE-1:0][WIDTH-1:0] stage_d;

  // Shift by one stage every cycle
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < int'(ENDING_CYCLE); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[ENDING_CYCLE-1];

endmodule

// File: rtl/mem_bank_scanner.sv
// Read-side sequencer for the banked operator/channel memory. A start pulse walks
// every (bank, address) pair once in bank-major order; returned data is tagged
// with a sideband delayed by the memory read latency.
// Ports: clk, reset (sync, active-high), start (scan request), en (scan enable),
//        reb/bankb/addrb (memory read port), dob (memory read data),
//        busy/done (scan status), out_valid/out_bank/out_addr/out_data (tagged word).
module mem_bank_scanner
  import mem_bank_scanner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 18,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned OUTPUT_DELAY = 2,
  parameter int unsigned BANK_WIDTH   = $clog2(NUM_BANKS),
  parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  en,
  output logic                  reb,
  output logic [BANK_WIDTH-1:0] bankb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  output logic [BANK_WIDTH-1:0] out_bank,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned DRAIN_W = 2;
  localparam int unsigned SB_W    = 1 + BANK_WIDTH + ADDR_WIDTH;

  scan_state_e           state_q, state_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_addr;
  logic                  last_bank;

  assign reb       = (state_q == SCAN) && en;
  assign last_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign last_bank = (bank_q == BANK_WIDTH'(NUM_BANKS - 1));

  // Next-state, counter and status logic
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          bank_d  = '0;
          addr_d  = '0;
        end
      end
      SCAN: begin
        if (reb) begin
          if (last_addr) begin
            addr_d = '0;
            if (last_bank) begin
              bank_d  = '0;
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              bank_d = bank_q + BANK_WIDTH'(1);
            end
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        // Final DRAIN cycle is the done cycle, one past the last out_valid
        if (drain_q == DRAIN_W'(OUTPUT_DELAY)) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN) && (drain_d == DRAIN_W'(OUTPUT_DELAY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q  <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bankb    = bank_q;
  assign addrb    = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = dob;

  // Sideband delay matches the memory read latency so tags line up with dob
  logic [SB_W-1:0] sb_in;
  logic [SB_W-1:0] sb_out;

  assign sb_in = {reb, bank_q, addr_q};

  generate
    if (OUTPUT_DELAY == 0) begin : g_no_delay
      assign sb_out = sb_in;
    end else begin : g_delay
      mem_bank_scanner_pipeline_sr #(
        .WIDTH       (SB_W),
        .ENDING_CYCLE(OUTPUT_DELAY)
      ) u_sideband_sr (
        .clk  (clk),
        .reset(reset),
        .d    (sb_in),
        .q    (sb_out)
      );
    end
  endgenerate

  assign {out_valid, out_bank, out_addr} = sb_out;

endmodule

// File: tb/tb_mem_bank_scanner.sv
module tb_mem_bank_scanner;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NB    = 2;
  localparam int BW    = 1;
  localparam int AW    = 2;
  localparam int N     = NB * DEPTH;
  localparam int MAXL  = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic en    = 1'b0;

  // DUT A: OUTPUT_DELAY = 2
  logic          reb_a, busy_a, done_a, ov_a;
  logic [BW-1:0] bankb_a, ob_a;
  logic [AW-1:0] addrb_a, oa_a;
  logic [DW-1:0] dob_a, od_a;
  // DUT B: OUTPUT_DELAY = 0
  logic          reb_b, busy_b, done_b, ov_b;
  logic [BW-1:0] bankb_b, ob_b;
  logic [AW-1:0] addrb_b, oa_b;
  logic [DW-1:0] dob_b, od_b;

  mem_bank_scanner #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .OUTPUT_DELAY(2),
                     .BANK_WIDTH(BW), .ADDR_WIDTH(AW)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .en(en),
    .reb(reb_a), .bankb(bankb_a), .addrb(addrb_a), .dob(dob_a),
    .busy(busy_a), .done(done_a), .out_valid(ov_a), .out_bank(ob_a),
    .out_addr(oa_a), .out_data(od_a));

  mem_bank_scanner #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .OUTPUT_DELAY(0),
                     .BANK_WIDTH(BW), .ADDR_WIDTH(AW)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .en(en),
    .reb(reb_b), .bankb(bankb_b), .addrb(addrb_b), .dob(dob_b),
    .busy(busy_b), .done(done_b), .out_valid(ov_b), .out_bank(ob_b),
    .out_addr(oa_b), .out_data(od_b));

  // Memory models: two-cycle registered read for A, asynchronous read for B
  logic [DW-1:0] mem [NB][DEPTH];
  logic [BW-1:0] pb1 = '0, pb2 = '0;
  logic [AW-1:0] pa1 = '0, pa2 = '0;
  always @(posedge clk) begin
    pb1 <= bankb_a; pa1 <= addrb_a;
    pb2 <= pb1;     pa2 <= pa1;
  end
  assign dob_a = mem[pb2][pa2];
  assign dob_b = mem[bankb_b][addrb_b];

  // Stimulus vectors and per-cycle output logs ([0] = DUT A, [1] = DUT B)
  bit st_v [MAXL];
  bit en_v [MAXL];
  bit rs_v [MAXL];
  int lg_reb [2][MAXL];
  int lg_bank[2][MAXL];
  int lg_addr[2][MAXL];
  int lg_busy[2][MAXL];
  int lg_done[2][MAXL];
  int lg_ov  [2][MAXL];
  int lg_ob  [2][MAXL];
  int lg_oa  [2][MAXL];
  int lg_od  [2][MAXL];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string what, input int c, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", what, c, act, exp);
    end
  endtask

  // Default stimulus: reset for two cycles, en high, no start
  task automatic clear_vec();
    for (int i = 0; i < MAXL; i++) begin
      st_v[i] = 1'b0;
      en_v[i] = 1'b1;
      rs_v[i] = (i < 2);
    end
  endtask

  task automatic run(input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      reset = rs_v[c];
      start = st_v[c];
      en    = en_v[c];
      @(negedge clk);
      lg_reb[0][c] = int'(reb_a);  lg_reb[1][c] = int'(reb_b);
      lg_bank[0][c] = int'(bankb_a); lg_bank[1][c] = int'(bankb_b);
      lg_addr[0][c] = int'(addrb_a); lg_addr[1][c] = int'(addrb_b);
      lg_busy[0][c] = int'(busy_a); lg_busy[1][c] = int'(busy_b);
      lg_done[0][c] = int'(done_a); lg_done[1][c] = int'(done_b);
      lg_ov[0][c] = int'(ov_a);     lg_ov[1][c] = int'(ov_b);
      lg_ob[0][c] = int'(ob_a);     lg_ob[1][c] = int'(ob_b);
      lg_oa[0][c] = int'(oa_a);     lg_oa[1][c] = int'(oa_b);
      lg_od[0][c] = int'(od_a);     lg_od[1][c] = int'(od_b);
    end
  endtask

  // Reference model: reads consume the next index of a bank-major list on every
  // enabled scan cycle; done lands od+1 cycles after the last read; the tagged
  // output is the read-side view od cycles earlier unless a reset fell in between.
  task automatic check_dut(input int d, input int od, input string tag, input int len);
    int m_reb[MAXL], m_bank[MAXL], m_addr[MAXL], m_busy[MAXL], m_done[MAXL];
    int mode, k, dcyc;
    mode = 0; k = 0; dcyc = 0;
    for (int c = 0; c < len; c++) begin
      m_reb[c] = 0; m_bank[c] = 0; m_addr[c] = 0; m_busy[c] = 0; m_done[c] = 0;
      if (mode == 1) begin
        m_busy[c] = 1;
        m_bank[c] = k / DEPTH;
        m_addr[c] = k % DEPTH;
        if (en_v[c]) begin
          m_reb[c] = 1;
          k++;
        end
      end else if (mode == 2) begin
        m_busy[c] = 1;
        if (c == dcyc) m_done[c] = 1;
      end
      if (rs_v[c]) begin
        mode = 0; k = 0;
      end else if (mode == 0 && st_v[c]) begin
        mode = 1; k = 0;
      end else if (mode == 1 && k == N) begin
        mode = 2; dcyc = c + od + 1;
      end else if (mode == 2 && c == dcyc) begin
        mode = 0;
      end
    end
    for (int c = 1; c < len; c++) begin
      int s, e_ov, e_ob, e_oa;
      bit wiped;
      s = c - od;
      wiped = (s < 0);
      for (int t = (s < 0 ? 0 : s); t < c; t++) if (rs_v[t]) wiped = 1'b1;
      e_ov = wiped ? 0 : m_reb[s];
      e_ob = wiped ? 0 : m_bank[s];
      e_oa = wiped ? 0 : m_addr[s];
      chk({tag, " reb"},       c, lg_reb[d][c],  m_reb[c]);
      chk({tag, " bankb"},     c, lg_bank[d][c], m_bank[c]);
      chk({tag, " addrb"},     c, lg_addr[d][c], m_addr[c]);
      chk({tag, " busy"},      c, lg_busy[d][c], m_busy[c]);
      chk({tag, " done"},      c, lg_done[d][c], m_done[c]);
      chk({tag, " out_valid"}, c, lg_ov[d][c],   e_ov);
      chk({tag, " out_bank"},  c, lg_ob[d][c],   e_ob);
      chk({tag, " out_addr"},  c, lg_oa[d][c],   e_oa);
      if (e_ov == 1)
        chk({tag, " out_data"}, c, lg_od[d][c], int'(mem[e_ob][e_oa]));
    end
  endtask

  task automatic check_both(input string tag, input int len);
    check_dut(0, 2, {tag, "/od2"}, len);
    check_dut(1, 0, {tag, "/od0"}, len);
  endtask

  // Beats of DUT d in [from, to) and their bank-major ordering
  task automatic check_beats(input int d, input string tag, input int from, input int to,
                             input int exp_beats);
    int beats;
    beats = 0;
    for (int c = from; c < to; c++) begin
      if (lg_ov[d][c] == 1) begin
        chk({tag, " order"}, c, lg_ob[d][c] * DEPTH + lg_oa[d][c], beats % N);
        beats++;
      end
    end
    chk({tag, " beats"}, to, beats, exp_beats);
  endtask

  typedef struct {
    int off;
    int reb, bank, addr, ov, obank, oaddr, busy, done;
  } vec_t;

  localparam int S = 3;

  initial begin
    vec_t vt[10];
    int dones;

    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++)
        mem[b][a] = DW'($urandom);

    // Expected OUTPUT_DELAY=2 timeline relative to the start cycle
    vt[0] = '{0,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1,  1, 0, 0, 0, 0, 0, 1, 0};
    vt[2] = '{2,  1, 0, 1, 0, 0, 0, 1, 0};
    vt[3] = '{3,  1, 0, 2, 1, 0, 0, 1, 0};
    vt[4] = '{5,  1, 1, 0, 1, 0, 2, 1, 0};
    vt[5] = '{8,  1, 1, 3, 1, 1, 1, 1, 0};
    vt[6] = '{9,  0, 0, 0, 1, 1, 2, 1, 0};
    vt[7] = '{10, 0, 0, 0, 1, 1, 3, 1, 0};
    vt[8] = '{11, 0, 0, 0, 0, 0, 0, 1, 1};
    vt[9] = '{12, 0, 0, 0, 0, 0, 0, 0, 0};

    // Basic contiguous scan
    clear_vec();
    st_v[S] = 1'b1;
    run(25);
    chk("reset reb", 2, lg_reb[0][2], 0);
    chk("reset busy", 2, lg_busy[0][2], 0);
    for (int i = 0; i < 10; i++) begin
      int c;
      c = S + vt[i].off;
      chk("vec reb",       c, lg_reb[0][c],  vt[i].reb);
      chk("vec bankb",     c, lg_bank[0][c], vt[i].bank);
      chk("vec addrb",     c, lg_addr[0][c], vt[i].addr);
      chk("vec out_valid", c, lg_ov[0][c],   vt[i].ov);
      chk("vec out_bank",  c, lg_ob[0][c],   vt[i].obank);
      chk("vec out_addr",  c, lg_oa[0][c],   vt[i].oaddr);
      chk("vec busy",      c, lg_busy[0][c], vt[i].busy);
      chk("vec done",      c, lg_done[0][c], vt[i].done);
    end
    chk("od0 done", S + 9, lg_done[1][S + 9], 1);
    for (int c = S + 1; c <= S + 8; c++) begin
      chk("od0 ov==reb", c, lg_ov[1][c], lg_reb[1][c]);
      chk("od0 data==dob", c, lg_od[1][c], int'(mem[lg_bank[1][c]][lg_addr[1][c]]));
    end
    check_both("basic", 25);

    // Pauses on the 3rd and 6th scan cycles
    clear_vec();
    st_v[S] = 1'b1;
    en_v[S + 3] = 1'b0;
    en_v[S + 6] = 1'b0;
    run(28);
    chk("pause done", S + 13, lg_done[0][S + 13], 1);
    check_beats(0, "pause/od2", 0, 28, N);
    check_both("pause", 28);

    // Start pulses during SCAN, DRAIN and on the done cycle
    clear_vec();
    st_v[S] = 1'b1;
    st_v[S + 4] = 1'b1;
    st_v[S + 9] = 1'b1;
    st_v[S + 11] = 1'b1;
    run(34);
    check_beats(0, "restart/od2", 0, 34, N);
    dones = 0;
    for (int c = 0; c < 34; c++) dones += lg_done[0][c];
    chk("restart/od2 dones", 34, dones, 1);
    check_both("restart", 34);

    // Reset on the 4th read cycle, then a fresh scan
    clear_vec();
    st_v[S] = 1'b1;
    rs_v[S + 4] = 1'b1;
    st_v[S + 8] = 1'b1;
    run(30);
    chk("rst reb",  S + 5, lg_reb[0][S + 5],  0);
    chk("rst busy", S + 5, lg_busy[0][S + 5], 0);
    chk("rst ov",   S + 5, lg_ov[0][S + 5],   0);
    chk("rst addrb", S + 5, lg_addr[0][S + 5], 0);
    check_beats(0, "rst/od2", S + 5, 30, N);
    check_beats(1, "rst/od0", S + 5, 30, N);
    check_both("rst", 30);

    // Back-to-back: od0 restarts at S+10, od2 at S+12 (each the cycle after its done)
    clear_vec();
    st_v[S] = 1'b1;
    st_v[S + 10] = 1'b1;
    st_v[S + 12] = 1'b1;
    run(40);
    chk("b2b/od2 first read", S + 13, lg_reb[0][S + 13], 1);
    chk("b2b/od0 first read", S + 11, lg_reb[1][S + 11], 1);
    check_beats(0, "b2b/od2", 0, 40, 2 * N);
    check_beats(1, "b2b/od0", 0, 40, 2 * N);
    check_both("b2b", 40);

    // Random en/start/reset against the reference model
    for (int r = 0; r < 6; r++) begin
      clear_vec();
      for (int c = 2; c < 70; c++) begin
        en_v[c] = ($urandom_range(99) < 70);
        st_v[c] = ($urandom_range(99) < 12);
        rs_v[c] = ($urandom_range(99) < 3);
      end
      run(70);
      check_both("rand", 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
